// File: rtl/axi4lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_slave
//   AXI4-Lite responder exposing NUM_REGS read/write registers at byte offsets
//   0x0, 0x4, ... Single-beat writes honour byte strobes; reads return the
//   addressed register. Accesses beyond the last register answer SLVERR,
//   leave the register file untouched and read back zero. The whole register
//   file is also driven flat on reg_out for downstream control logic.
//
// Ports
//   ACLK, ARESET            clock (rising edge), asynchronous active-high reset
//   S_AXI_AW*               write address channel (AWPROT ignored)
//   S_AXI_W*                write data channel with byte strobes
//   S_AXI_B*                write response channel (00 OKAY, 10 SLVERR)
//   S_AXI_AR*               read address channel (ARPROT ignored)
//   S_AXI_R*                read data channel (00 OKAY, 10 SLVERR)
//   reg_out                 register k on bits [32k+31:32k]
//
// Only a 32-bit data width is supported; address bits [1:0] are ignored.
// -----------------------------------------------------------------------------
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = AW - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_WAIT_D = 2'd1,
    W_WAIT_A = 2'd2,
    W_RESP   = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // True when the word index addresses an implemented register.
  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    idx_valid = (32'(idx) < 32'(NUM_REGS));
  endfunction

  // Byte-wise merge of new data into the old register value under the strobes.
  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_val;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    strb_merge = res;
  endfunction

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  w_state_e        w_state_q, w_state_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [AW-1:0]   awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;

  logic            aw_hs_s, w_hs_s, b_hs_s;
  logic            wr_commit_s;
  logic [AW-1:0]   wr_addr_s;
  logic [DW-1:0]   wr_data_s;
  logic [SW-1:0]   wr_strb_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic            wr_ok_s;

  logic [DW-1:0]   regs_q [NUM_REGS];

  assign aw_hs_s  = S_AXI_AWVALID & awready_q;
  assign w_hs_s   = S_AXI_WVALID  & wready_q;
  assign b_hs_s   = bvalid_q      & S_AXI_BREADY;
  assign wr_idx_s = wr_addr_s[AW-1:2];
  assign wr_ok_s  = idx_valid(wr_idx_s);

  // Write FSM next state: AW and W may arrive together or in either order.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_state_d = W_RESP;
        end else if (aw_hs_s) begin
          w_state_d = W_WAIT_D;
        end else if (w_hs_s) begin
          w_state_d = W_WAIT_A;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_WAIT_D: begin
        if (w_hs_s) begin
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_WAIT_D;
        end
      end
      W_WAIT_A: begin
        if (aw_hs_s) begin
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_WAIT_A;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Commit selection: the half that arrives last is taken live from the bus,
  // the half that arrived earlier comes from the holding registers.
  always_comb begin
    wr_commit_s = 1'b0;
    wr_addr_s   = awaddr_q;
    wr_data_s   = wdata_q;
    wr_strb_s   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        wr_commit_s = aw_hs_s & w_hs_s;
        wr_addr_s   = S_AXI_AWADDR;
        wr_data_s   = S_AXI_WDATA;
        wr_strb_s   = S_AXI_WSTRB;
      end
      W_WAIT_D: begin
        wr_commit_s = w_hs_s;
        wr_data_s   = S_AXI_WDATA;
        wr_strb_s   = S_AXI_WSTRB;
      end
      W_WAIT_A: begin
        wr_commit_s = aw_hs_s;
        wr_addr_s   = S_AXI_AWADDR;
      end
      default: begin
        wr_commit_s = 1'b0;
      end
    endcase
  end

  // Write FSM outputs, computed from the next state so they can be registered.
  always_comb begin
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_A);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_D);
    bvalid_d  = (w_state_d == W_RESP);
    if (wr_commit_s) begin
      bresp_d = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      bresp_d = bresp_q;
    end
  end

  // Write FSM state, registered handshake outputs and the early-half holding registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      if (aw_hs_s) begin
        awaddr_q <= S_AXI_AWADDR;
      end
      if (w_hs_s) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file; out-of-range commits fall through without touching any register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_commit_s && wr_ok_s && (32'(wr_idx_s) == 32'(k))) begin
          regs_q[k] <= strb_merge(regs_q[k], wr_data_s, wr_strb_s);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  r_state_e         r_state_q, r_state_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic             ar_hs_s, r_hs_s;
  logic [IDX_W-1:0] ar_idx_s;
  logic             ar_ok_s;
  logic [DW-1:0]    rd_sel_s;

  assign ar_hs_s  = S_AXI_ARVALID & arready_q;
  assign r_hs_s   = rvalid_q & S_AXI_RREADY;
  assign ar_idx_s = S_AXI_ARADDR[AW-1:2];
  assign ar_ok_s  = idx_valid(ar_idx_s);

  // Read mux over the current register contents; a write committing on the
  // same edge is not yet visible, so a colliding read gets the old value.
  always_comb begin
    rd_sel_s = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_sel_s = (32'(ar_idx_s) == 32'(k)) ? regs_q[k] : rd_sel_s;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs_s) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; data and response are only reloaded on an AR handshake.
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    if (ar_hs_s) begin
      rdata_d = ar_ok_s ? rd_sel_s : '0;
      rresp_d = ar_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
  end

  // Read FSM state and registered read-channel outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[DW*k +: DW] = regs_q[k];
  end

  // Protection bits and the byte-lane address bits carry no meaning here.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
module tb_axi4lite_reg_slave;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [4:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [4:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_out;

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [4];
  logic [4:0]  aw_pend [$];
  logic [35:0] w_pend  [$];
  logic [1:0]  b_exp   [$];
  logic [33:0] r_exp   [$];
  bit          exp_b_next, exp_r_next;
  bit          prev_bstall, prev_rstall;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;

  // Scoreboard: observe handshakes, apply the register-file rules.
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < 4; k++) m_regs[k] = 32'h0;
      aw_pend.delete(); w_pend.delete(); b_exp.delete(); r_exp.delete();
      exp_b_next = 1'b0; exp_r_next = 1'b0;
      prev_bstall = 1'b0; prev_rstall = 1'b0;
    end else begin
      logic [4:0]  a;
      logic [35:0] w;
      logic [33:0] re;
      int          idx;
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        chk("b_expected", 32'(b_exp.size() > 0), 32'd1);
        if (b_exp.size() > 0) chk("bresp", 32'(S_AXI_BRESP), 32'(b_exp.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        chk("r_expected", 32'(r_exp.size() > 0), 32'd1);
        if (r_exp.size() > 0) begin
          re = r_exp.pop_front();
          chk("rdata", S_AXI_RDATA, re[31:0]);
          chk("rresp", 32'(S_AXI_RRESP), 32'(re[33:32]));
        end
      end
      // read sees register contents before any write landing on this edge
      exp_r_next = 1'b0;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        chk("ar_during_r", 32'(S_AXI_RVALID), 32'd0);
        idx = int'(S_AXI_ARADDR[4:2]);
        if (idx < 4) r_exp.push_back({2'b00, m_regs[idx]});
        else         r_exp.push_back({2'b10, 32'h0});
        exp_r_next = 1'b1;
      end
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        chk("aw_during_b", 32'(S_AXI_BVALID), 32'd0);
        aw_pend.push_back(S_AXI_AWADDR);
      end
      if (S_AXI_WVALID && S_AXI_WREADY) w_pend.push_back({S_AXI_WSTRB, S_AXI_WDATA});
      exp_b_next = 1'b0;
      if (aw_pend.size() > 0 && w_pend.size() > 0) begin
        a = aw_pend.pop_front();
        w = w_pend.pop_front();
        idx = int'(a[4:2]);
        if (idx < 4) begin
          for (int b = 0; b < 4; b++)
            if (w[32+b]) m_regs[idx][8*b +: 8] = w[8*b +: 8];
          b_exp.push_back(2'b00);
        end else begin
          b_exp.push_back(2'b10);
        end
        exp_b_next = 1'b1;
      end
      prev_bstall = S_AXI_BVALID && !S_AXI_BREADY;
      prev_bresp  = S_AXI_BRESP;
      prev_rstall = S_AXI_RVALID && !S_AXI_RREADY;
      prev_rresp  = S_AXI_RRESP;
      prev_rdata  = S_AXI_RDATA;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      for (int k = 0; k < 4; k++) chk("reg_out", reg_out[32*k +: 32], m_regs[k]);
      chk("bvalid_state", 32'(S_AXI_BVALID), 32'(b_exp.size() > 0));
      chk("rvalid_state", 32'(S_AXI_RVALID), 32'(r_exp.size() > 0));
      if (exp_b_next) chk("b_latency", 32'(S_AXI_BVALID), 32'd1);
      if (exp_r_next) chk("r_latency", 32'(S_AXI_RVALID), 32'd1);
      if (prev_bstall) begin
        chk("b_hold", 32'(S_AXI_BVALID), 32'd1);
        chk("bresp_hold", 32'(S_AXI_BRESP), 32'(prev_bresp));
      end
      if (prev_rstall) begin
        chk("r_hold", 32'(S_AXI_RVALID), 32'd1);
        chk("rdata_hold", S_AXI_RDATA, prev_rdata);
        chk("rresp_hold", 32'(S_AXI_RRESP), 32'(prev_rresp));
      end
    end
  end

  // ---------------- drivers (enter and leave just after a falling edge) ----------------
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit wait_b,
                           output logic [1:0] resp);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs, bv, hs, done = 1'b0;
    int c = 0, guard = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && guard < 200) begin
      S_AXI_AWVALID = !aw_done && (c >= aw_dly);
      S_AXI_WVALID  = !w_done && (c >= w_dly);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
      @(negedge ACLK);
      c++; guard++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("write_addr_data_timeout", 32'(guard < 200), 32'd1);
    resp = 2'b11;
    if (wait_b) begin
      c = 0; guard = 0;
      while (!done && guard < 200) begin
        bv = S_AXI_BVALID;
        S_AXI_BREADY = bv && (c >= b_dly);
        hs = bv && S_AXI_BREADY;
        if (hs) resp = S_AXI_BRESP;
        @(posedge ACLK);
        if (hs) done = 1'b1;
        if (bv) c++;
        @(negedge ACLK);
        guard++;
      end
      S_AXI_BREADY = 1'b0;
      chk("write_resp_timeout", 32'(done), 32'd1);
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 1'b0, ar_hs, rv, hs, done = 1'b0;
    int c = 0, guard = 0;
    S_AXI_ARADDR = addr;
    while (!ar_done && guard < 200) begin
      S_AXI_ARVALID = (c >= ar_dly);
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK);
      if (ar_hs) ar_done = 1'b1;
      @(negedge ACLK);
      c++; guard++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("read_addr_timeout", 32'(ar_done), 32'd1);
    data = 32'hDEADBEEF; resp = 2'b11;
    c = 0; guard = 0;
    while (!done && guard < 200) begin
      rv = S_AXI_RVALID;
      S_AXI_RREADY = rv && (c >= r_dly);
      hs = rv && S_AXI_RREADY;
      if (hs) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      @(posedge ACLK);
      if (hs) done = 1'b1;
      if (rv) c++;
      @(negedge ACLK);
      guard++;
    end
    S_AXI_RREADY = 1'b0;
    chk("read_data_timeout", 32'(done), 32'd1);
  endtask

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  rs, rs2;
    int          guard;
    ARESET = 1'b1;
    S_AXI_AWADDR = 5'h0; S_AXI_AWPROT = 3'h0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 5'h0; S_AXI_ARPROT = 3'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    chk("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
    chk("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
    chk("rst_rdata",   S_AXI_RDATA,        32'd0);
    for (int k = 0; k < 4; k++) chk("rst_reg_out", reg_out[32*k +: 32], 32'd0);
    ARESET = 1'b0;

    // T1: write 1..4, read back
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0, 1'b1, rs);
      chk("t1_bresp", 32'(rs), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4*i), 0, 0, d, rs);
      chk("t1_rdata", d, 32'(i + 1));
      chk("t1_rresp", 32'(rs), 32'd0);
    end

    // T2: W three cycles ahead of AW
    axi_write(5'h04, 32'hA5A5A5A5, 4'hF, 3, 0, 0, 1'b1, rs);
    chk("t2_bresp", 32'(rs), 32'd0);
    chk("t2_reg1", reg_out[63:32], 32'hA5A5A5A5);
    // AW ahead of W as well
    axi_write(5'h0C, 32'h00000004, 4'hF, 0, 2, 0, 1'b1, rs);
    chk("t2b_bresp", 32'(rs), 32'd0);

    // T3: partial strobes
    axi_write(5'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b1, rs);
    axi_write(5'h08, 32'h12345678, 4'b0101, 0, 0, 0, 1'b1, rs);
    chk("t3_reg2", reg_out[95:64], 32'hFF34FF78);

    // T4: out of range
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b1, rs);
    chk("t4_bresp", 32'(rs), 32'd2);
    axi_read(5'h14, 0, 0, d, rs);
    chk("t4_rresp", 32'(rs), 32'd2);
    chk("t4_rdata", d, 32'd0);
    chk("t4_reg0", reg_out[31:0],   32'd1);
    chk("t4_reg1", reg_out[63:32],  32'hA5A5A5A5);
    chk("t4_reg2", reg_out[95:64],  32'hFF34FF78);
    chk("t4_reg3", reg_out[127:96], 32'd4);

    // T5: long stall on B and R; extra AW/AR must not be taken
    fork
      axi_write(5'h00, 32'hCAFE0001, 4'hF, 0, 0, 10, 1'b1, rs);
      begin
        guard = 0;
        while (!S_AXI_BVALID && guard < 20) begin @(negedge ACLK); guard++; end
        chk("t5_bvalid_seen", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        repeat (5) begin
          chk("t5_no_aw", 32'(S_AXI_AWREADY), 32'd0);
          @(negedge ACLK);
        end
        S_AXI_AWVALID = 1'b0;
      end
    join
    chk("t5_bresp", 32'(rs), 32'd0);
    fork
      axi_read(5'h08, 0, 10, d, rs);
      begin
        guard = 0;
        while (!S_AXI_RVALID && guard < 20) begin @(negedge ACLK); guard++; end
        chk("t5_rvalid_seen", 32'(S_AXI_RVALID), 32'd1);
        repeat (5) begin
          S_AXI_ARVALID = 1'b1; // ARADDR already held by the read task
          chk("t5_no_ar", 32'(S_AXI_ARREADY), 32'd0);
          @(negedge ACLK);
        end
        S_AXI_ARVALID = 1'b0;
      end
    join
    chk("t5_rdata", d, 32'hFF34FF78);

    // T6: reset while a response is pending
    axi_write(5'h04, 32'h11111111, 4'hF, 0, 0, 0, 1'b0, rs);
    guard = 0;
    while (!S_AXI_BVALID && guard < 10) begin @(negedge ACLK); guard++; end
    chk("t6_bvalid_before", 32'(S_AXI_BVALID), 32'd1);
    ARESET = 1'b1;
    #1;
    chk("t6_bvalid_dropped", 32'(S_AXI_BVALID), 32'd0);
    chk("t6_regs_cleared", reg_out[31:0] | reg_out[63:32] | reg_out[95:64] | reg_out[127:96], 32'd0);
    @(negedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    axi_write(5'h08, 32'h00000005, 4'hF, 0, 0, 0, 1'b1, rs);
    chk("t6_bresp", 32'(rs), 32'd0);
    chk("t6_reg2", reg_out[95:64], 32'd5);

    // simultaneous commit and capture on reg0: read sees the old value
    fork
      axi_write(5'h00, 32'h00000077, 4'hF, 0, 0, 0, 1'b1, rs);
      axi_read(5'h00, 0, 0, d, rs2);
    join
    chk("collide_rdata_old", d, 32'd0);
    axi_read(5'h00, 0, 0, d, rs2);
    chk("collide_rdata_new", d, 32'h77);

    // zero strobes: OKAY, register untouched
    axi_write(5'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1'b1, rs);
    chk("strb0_bresp", 32'(rs), 32'd0);
    chk("strb0_reg2", reg_out[95:64], 32'd5);

    // randomized traffic, checked by the scoreboard
    for (int n = 0; n < 80; n++) begin
      logic [4:0] wa, ra;
      int op;
      op = int'($urandom_range(0, 2));
      wa = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      case (op)
        0: axi_write(wa, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, rs);
        1: axi_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, rs2);
        default: fork
          axi_write(wa, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1, rs);
          axi_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), d, rs2);
        join
      endcase
    end

    repeat (3) @(negedge ACLK);
    chk("end_no_pending_b", 32'(b_exp.size()), 32'd0);
    chk("end_no_pending_r", 32'(r_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
